// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Command sequencer in front of the 16-bit combinational execute-stage ALU.
// A request (function + two 32-bit operands) is accepted over a valid/ready
// handshake. The sequencer then drives the ALU for one pass (16-bit functions)
// or two carry-chained passes (ADD32/SUB32) and registers each pass result.
// Set-condition results are derived from the ALU ofl/Z flags. The registered
// 32-bit result and its flags are returned over a second valid/ready handshake.
//
// Ports
//   clk, rst         : clock; asynchronous active-high reset
//   req_valid/ready  : request handshake (ready only while idle, no buffering)
//   req_func [2:0]   : 0 ADD, 1 SUB, 2 SEQ, 3 SLT, 4 SLE, 5 SCO, 6 ADD32, 7 SUB32
//   req_a/req_b[31:0]: operands; upper halves used only by ADD32/SUB32
//   alu_A/alu_B[15:0]: ALU operands
//   alu_cin          : ALU carry-in
//   alu_op [2:0]     : ALU operation, always arithmetic add (3'b100)
//   alu_invA/invB    : ALU operand inversion
//   alu_sign         : 1 = alu_ofl reports signed overflow, 0 = carry-out
//   alu_out/ofl/Z    : combinational ALU result and flags
//   rsp_valid/ready  : response handshake
//   rsp_data [31:0]  : result
//   rsp_ofl          : signed overflow of the final pass (0 for set ops)
//   rsp_z            : result is zero
// -----------------------------------------------------------------------------
module alu_seq (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,

  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic        alu_cin,
  output logic [2:0]  alu_op,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl,
  input  logic        alu_Z,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_ofl,
  output logic        rsp_z
);

  localparam logic [2:0] ALU_OP_ADD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC_LO,
    ST_EXEC_HI,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    F_ADD   = 3'd0,
    F_SUB   = 3'd1,
    F_SEQ   = 3'd2,
    F_SLT   = 3'd3,
    F_SLE   = 3'd4,
    F_SCO   = 3'd5,
    F_ADD32 = 3'd6,
    F_SUB32 = 3'd7
  } func_e;

  state_e      state_q,    state_d;
  func_e       func_q,     func_d;
  logic [31:0] a_q,        a_d;
  logic [31:0] b_q,        b_d;
  logic        carry_q,    carry_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_ofl_q,  rsp_ofl_d;
  logic        rsp_z_q,    rsp_z_d;

  // Signed less-than from an A-B pass run with signed overflow reporting:
  // the sign of the difference is wrong exactly when the subtraction overflowed.
  logic lt;
  assign lt = alu_out[15] ^ alu_ofl;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: operand and result registers are reset along with the state so that
  // rsp_data and the ALU operands come out of reset at a known zero value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      func_q     <= F_ADD;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_ofl_q  <= 1'b0;
      rsp_z_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q    <= state_d;
      func_q     <= func_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      rsp_data_q <= rsp_data_d;
      rsp_ofl_q  <= rsp_ofl_d;
      rsp_z_q    <= rsp_z_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU drive: depends only on registered state, so the external combinational
  // ALU never closes a loop through this module's next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first; any path that skips an
    // assignment would otherwise infer a latch.
    alu_A    = 16'h0;
    alu_B    = 16'h0;
    alu_cin  = 1'b0;
    alu_op   = ALU_OP_ADD;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b1;

    unique case (state_q)
      ST_EXEC_LO: begin
        alu_A = a_q[15:0];
        alu_B = b_q[15:0];
        unique case (func_q)
          F_ADD: ;
          F_SUB, F_SEQ, F_SLT, F_SLE: begin
            alu_invB = 1'b1;
            alu_cin  = 1'b1;
          end
          // Carry-out is what SCO reports and what ADD32 chains upward.
          F_SCO, F_ADD32: alu_sign = 1'b0;
          F_SUB32: begin
            alu_invB = 1'b1;
            alu_cin  = 1'b1;
            alu_sign = 1'b0;
          end
        endcase
      end
      ST_EXEC_HI: begin
        alu_A    = a_q[31:16];
        alu_B    = b_q[31:16];
        alu_cin  = carry_q;
        alu_invB = (func_q == F_SUB32);
        alu_sign = 1'b1;
      end
      ST_IDLE, ST_RESP: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and result capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    rsp_data_d = rsp_data_q;
    rsp_ofl_d  = rsp_ofl_q;
    rsp_z_d    = rsp_z_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          func_d  = func_e'(req_func);
          a_d     = req_a;
          b_d     = req_b;
          carry_d = 1'b0;
          state_d = ST_EXEC_LO;
        end
      end

      ST_EXEC_LO: begin
        state_d   = ST_RESP;
        rsp_ofl_d = 1'b0;
        unique case (func_q)
          F_ADD, F_SUB: begin
            rsp_data_d = {16'h0, alu_out};
            rsp_ofl_d  = alu_ofl;
          end
          F_SEQ: rsp_data_d = {31'h0, alu_Z};
          F_SLT: rsp_data_d = {31'h0, lt};
          F_SLE: rsp_data_d = {31'h0, lt | alu_Z};
          F_SCO: rsp_data_d = {31'h0, alu_ofl};
          F_ADD32, F_SUB32: begin
            // Low half parked in the result register; the high pass
            // completes the word and recomputes the flags.
            rsp_data_d = {16'h0, alu_out};
            carry_d    = alu_ofl;
            state_d    = ST_EXEC_HI;
          end
        endcase
        rsp_z_d = (rsp_data_d == 32'h0);
      end

      ST_EXEC_HI: begin
        rsp_data_d = {alu_out, rsp_data_q[15:0]};
        rsp_ofl_d  = alu_ofl;
        rsp_z_d    = (rsp_data_d == 32'h0);
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_ofl   = rsp_ofl_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Scoreboard bench for alu_seq. A behavioural model of the external 16-bit
// ALU is attached to the ALU ports. Expected responses are computed from the
// operation definitions with plain integer arithmetic, pushed when a request
// is accepted, and popped by an independent monitor on each response
// handshake, which also checks response latency and hold stability.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic        alu_cin;
  logic [2:0]  alu_op;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_out;
  logic        alu_ofl;
  logic        alu_Z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ofl;
  logic        rsp_z;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func  (req_func),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_cin   (alu_cin),
    .alu_op    (alu_op),
    .alu_invA  (alu_invA),
    .alu_invB  (alu_invB),
    .alu_sign  (alu_sign),
    .alu_out   (alu_out),
    .alu_ofl   (alu_ofl),
    .alu_Z     (alu_Z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ofl   (rsp_ofl),
    .rsp_z     (rsp_z)
  );

  // External ALU: out = (A^invA) + (B^invB) + cin, flags as documented.
  logic [15:0] opa, opb;
  logic [16:0] sum;
  always_comb begin
    opa     = alu_A ^ {16{alu_invA}};
    opb     = alu_B ^ {16{alu_invB}};
    sum     = {1'b0, opa} + {1'b0, opb} + {16'h0, alu_cin};
    alu_out = sum[15:0];
    alu_ofl = alu_sign ? ((opa[15] == opb[15]) && (sum[15] != opa[15])) : sum[16];
    alu_Z   = (sum[15:0] == 16'h0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        ofl;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Reference model: the operation definitions as integer arithmetic.
  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          sa, sbv, ua, ub, r;
    longint      r64;
    logic [63:0] rv;
    sa  = int'($signed(a[15:0]));
    sbv = int'($signed(b[15:0]));
    ua  = int'(a[15:0]);
    ub  = int'(b[15:0]);
    e.ofl = 1'b0;
    e.due = 0;
    case (f)
      3'd0, 3'd1: begin
        r      = (f == 3'd0) ? sa + sbv : sa - sbv;
        rv     = 64'(r);
        e.data = {16'h0, rv[15:0]};
        e.ofl  = (r > 32767) || (r < -32768);
      end
      3'd2: e.data = 32'(sa == sbv);
      3'd3: e.data = 32'(sa < sbv);
      3'd4: e.data = 32'(sa <= sbv);
      3'd5: e.data = 32'((ua + ub) > 65535);
      default: begin
        r64    = (f == 3'd6) ? longint'($signed(a)) + longint'($signed(b))
                             : longint'($signed(a)) - longint'($signed(b));
        rv     = 64'(r64);
        e.data = rv[31:0];
        e.ofl  = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
    endcase
    e.z = (e.data == 32'h0);
    return e;
  endfunction

  // Drive one request; returns the cycle number just after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    acc  = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 60 && !done; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc   = cyc;
        done  = 1'b1;
        e     = model(f, a, b);
        e.due = cyc + ((f >= 3'd6) ? 2 : 1);
        sb.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(req_ready), 32'h1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  // Monitor: latency on first valid, stability while held, data on handshake.
  bit          started = 1'b0;
  bit          held    = 1'b0;
  logic [31:0] prev_data;
  logic        prev_ofl, prev_z;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      started = 1'b0;
      held    = 1'b0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        if (!started) begin
          started = 1'b1;
          check("rsp_latency", 32'(cyc), 32'(sb[0].due));
        end
        if (held) begin
          check("hold_data", rsp_data, prev_data);
          check("hold_ofl",  32'(rsp_ofl), 32'(prev_ofl));
          check("hold_z",    32'(rsp_z),   32'(prev_z));
          check("hold_req_ready", 32'(req_ready), 32'h0);
        end
        if (rsp_ready) begin
          e = sb.pop_front();
          check("rsp_data", rsp_data,      e.data);
          check("rsp_ofl",  32'(rsp_ofl),  32'(e.ofl));
          check("rsp_z",    32'(rsp_z),    32'(e.z));
          started = 1'b0;
          held    = 1'b0;
        end else begin
          held      = 1'b1;
          prev_data = rsp_data;
          prev_ofl  = rsp_ofl;
          prev_z    = rsp_z;
        end
      end
    end
  end

  bit rand_bp = 1'b0;

  initial begin
    int acc, acc1, hs, k;
    int a0, a1, a2, a3;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_func  = 3'd0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  rsp_data,       32'h0);
    check("rst_rsp_ofl",   32'(rsp_ofl),   32'h0);
    check("rst_rsp_z",     32'(rsp_z),     32'h0);
    check("rst_alu_ctl",   {24'h0, alu_op, alu_invA, alu_invB, alu_sign, alu_cin, 1'b0},
                           {24'h0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("rst_alu_ab",    {alu_A, alu_B}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of ADD32 (during EXEC_HI) aborts it.
    issue(3'd6, 32'h1234_5678, 32'h0000_0001, acc);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_alu_a",     32'(alu_A),     32'h0);
    sb.delete(sb.size() - 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // Directed 16-bit cases with low-pass control checks.
    issue(3'd0, 32'h0000_7FFF, 32'h0000_0001, acc);
    check("add_lo_ctl", {29'h0, alu_invB, alu_cin, alu_sign}, 32'h1);
    wait_drain();
    issue(3'd1, 32'h0000_0005, 32'h0000_0005, acc);
    check("sub_lo_ctl", {29'h0, alu_invB, alu_cin, alu_sign}, 32'h7);
    wait_drain();
    issue(3'd3, 32'h0000_8000, 32'h0000_0001, acc);
    issue(3'd3, 32'h0000_7FFF, 32'h0000_FFFF, acc);
    issue(3'd4, 32'h0000_1234, 32'h0000_1234, acc);
    issue(3'd2, 32'h0000_0005, 32'h0000_0006, acc);
    issue(3'd5, 32'h0000_FFFF, 32'h0000_0001, acc);
    check("sco_lo_ctl", {29'h0, alu_invB, alu_cin, alu_sign}, 32'h0);
    issue(3'd5, 32'h0000_0001, 32'h0000_0001, acc);
    wait_drain();

    // 32-bit cases: carry chained into the high pass.
    issue(3'd6, 32'h0000_FFFF, 32'h0000_0001, acc);
    @(posedge clk);
    #1;
    check("add32_hi_ctl", {29'h0, alu_invB, alu_cin, alu_sign}, 32'h3);
    check("add32_hi_a",   32'(alu_A), 32'h0);
    wait_drain();
    issue(3'd7, 32'h0001_0000, 32'h0000_0001, acc);
    check("sub32_lo_ctl", {29'h0, alu_invB, alu_cin, alu_sign}, 32'h6);
    @(posedge clk);
    #1;
    check("sub32_hi_ctl", {29'h0, alu_invB, alu_cin, alu_sign}, 32'h5);
    wait_drain();
    issue(3'd6, 32'h7FFF_FFFF, 32'h0000_0001, acc);
    wait_drain();

    // Backpressure with a competing request.
    rsp_ready = 1'b0;
    hs   = -100;
    acc1 = -1;
    issue(3'd0, 32'h0000_1111, 32'h0000_2222, acc);
    fork
      issue(3'd1, 32'h0000_0100, 32'h0000_0300, acc1);
      begin
        k = 0;
        while (!rsp_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 4; i++) begin
          check("bp_req_ready", 32'(req_ready), 32'h0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hs = cyc;
      end
    join
    check("bp_accept_cycle", 32'(acc1), 32'(hs + 1));
    wait_drain();

    // Back-to-back issue intervals: ADD, ADD32, SEQ, then one more.
    issue(3'd0, 32'h0000_0003, 32'h0000_0004, a0);
    issue(3'd6, 32'h0001_0002, 32'h0003_0004, a1);
    issue(3'd2, 32'h0000_0009, 32'h0000_0009, a2);
    issue(3'd0, 32'h0000_0001, 32'h0000_0001, a3);
    check("interval_add",   32'(a1 - a0), 32'd3);
    check("interval_add32", 32'(a2 - a1), 32'd4);
    check("interval_seq",   32'(a3 - a2), 32'd3);
    wait_drain();

    // Randomized traffic under random response backpressure.
    rand_bp = 1'b1;
    fork
      while (rand_bp) begin
        @(posedge clk);
        #1;
        rsp_ready = 1'($urandom_range(0, 1));
      end
      begin
        for (int i = 0; i < 150; i++) begin
          logic [31:0] ra, rb;
          ra = $urandom;
          rb = $urandom;
          if ($urandom_range(0, 3) == 0) rb = ra;
          issue(3'($urandom_range(0, 7)), ra, rb, acc);
        end
        rand_bp = 1'b0;
      end
    join
    rsp_ready = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer driving the 16-bit combinational execute-stage ALU. Accepts one arithmetic/compare request at a time over a valid/ready handshake and drives the ALU control and operand ports. For 32-bit ops it runs two carry-chained passes. It registers each pass result and derives set-condition values from the ALU `ofl`/`Z` flags. It returns a registered 32-bit result with flags over a second valid/ready handshake.

## Interface
Parameters: none (datapath fixed at 16-bit ALU, 32-bit request/response).

Clock and reset:
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: asynchronous, active-high reset

Request side:
- `req_valid` in 1: request present
- `req_ready` out 1: sequencer idle; accepts when `req_valid & req_ready`
- `req_func` in 3: 0 ADD, 1 SUB, 2 SEQ, 3 SLT, 4 SLE, 5 SCO, 6 ADD32, 7 SUB32
- `req_a` in 32: operand A; bits [31:16] used only by ADD32/SUB32
- `req_b` in 32: operand B; same rule

ALU side:
- `alu_A` out 16: ALU operand A
- `alu_B` out 16: ALU operand B
- `alu_cin` out 1: ALU carry-in
- `alu_op` out 3: ALU op; always 3'b100 (arithmetic add)
- `alu_invA` out 1: invert A
- `alu_invB` out 1: invert B
- `alu_sign` out 1: 1 = `ofl` is signed overflow; 0 = `ofl` is unsigned carry-out
- `alu_out` in 16: combinational ALU result, equal to (A^{16{invA}}) + (B^{16{invB}}) + cin
- `alu_ofl` in 1: ALU overflow/carry flag
- `alu_Z` in 1: ALU zero flag

Response side:
- `rsp_valid` out 1: result present
- `rsp_ready` in 1: consumer takes result when `rsp_valid & rsp_ready`
- `rsp_data` out 32: result
- `rsp_ofl` out 1: signed overflow of the final pass
- `rsp_z` out 1: result is zero

## Operation
- FSM states: IDLE, EXEC_LO, EXEC_HI, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, latch func and operands, then go to EXEC_LO.
- EXEC_LO:
  - Drive ALU with A[15:0], B[15:0].
  - Register the pass result at the end of the cycle.
  - Go to EXEC_HI for ADD32/SUB32; otherwise go to RESP.
- EXEC_HI:
  - Drive A[31:16], B[31:16], with `alu_cin` = carry captured in EXEC_LO.
  - Register the result, then go to RESP.
- RESP:
  - `rsp_valid`=1; outputs held stable.
  - On `rsp_ready`, go to IDLE.
- Pass controls, as (invB, cin, sign):

  | Func | Low pass | High pass |
  |---|---|---|
  | ADD | (0,0,1) | — |
  | SUB, SEQ, SLT, SLE | (1,1,1) | — |
  | SCO | (0,0,0) | — |
  | ADD32 | (0,0,0), carry=`alu_ofl` | (0,carry,1) |
  | SUB32 | (1,1,0), carry=`alu_ofl` | (1,carry,1) |

  `alu_invA` is always 0.
- Results:
  - ADD/SUB: `rsp_data` = {16'h0, out}.
  - SEQ = Z.
  - SLT = out[15]^ofl.
  - SLE = SLT|Z.
  - SCO = ofl. Set ops return 32'h0 or 32'h1.
  - ADD32/SUB32: `rsp_data` = {hi_out, lo_out}.
- Flags:
  - `rsp_ofl` = `alu_ofl` of the final signed pass for ADD/SUB/ADD32/SUB32; 0 for set ops.
  - `rsp_z` = (`rsp_data`==0).
- Outside EXEC states, ALU outputs are driven to A=B=0, cin=invA=invB=0, sign=1, op=3'b100.
- Requests presented while not IDLE are ignored (`req_ready`=0). No buffering.

## Timing
- Reset (async, immediate):
  - State → IDLE; `req_ready`=1.
  - `rsp_valid`=0; `rsp_data`=0; `rsp_ofl`=0; `rsp_z`=0.
  - ALU outputs take their idle values.
- Latency from the accept edge (cycle 0):
  - 16-bit funcs: EXEC_LO in cycle 1; `rsp_valid` in cycle 2.
  - 32-bit funcs: EXEC_LO in cycle 1, EXEC_HI in cycle 2; `rsp_valid` in cycle 3.
- Throughput:
  - Response consumed in cycle N → `req_ready`=1 in cycle N+1.
  - Minimum issue interval is 3 cycles for 16-bit funcs and 4 for 32-bit funcs.
- The ALU is combinational. Its outputs are sampled only at the rising edge ending an EXEC cycle.
- The carry between passes is a registered bit and is cleared on accept.
- Reset during EXEC or RESP aborts the operation. No response is produced and the sequencer is ready again immediately.

## Test plan
- Reset mid-ADD32 (assert `rst` during EXEC_HI) → `rsp_valid`=0 and `req_ready`=1 immediately. No response after release.
- ADD 0x7FFF+0x0001 → `rsp_data`=0x00008000, `rsp_ofl`=1, `rsp_z`=0, `rsp_valid` in cycle 2. SUB 0x0005-0x0005 → `rsp_data`=0, `rsp_z`=1, `rsp_ofl`=0.
- Set ops:
  - SLT A=0x8000, B=0x0001 → 1.
  - SLT A=0x7FFF, B=0xFFFF → 0.
  - SLE A=B=0x1234 → 1.
  - SEQ 5 vs 6 → 0.
  - SCO 0xFFFF+0x0001 → 1.
  - SCO 0x0001+0x0001 → 0.
- ADD32 0x0000FFFF+0x00000001 → 0x00010000, `rsp_ofl`=0, `rsp_valid` in cycle 3; high pass shows `alu_cin`=1. SUB32 0x00010000-0x00000001 → 0x0000FFFF. ADD32 0x7FFFFFFF+1 → 0x80000000, `rsp_ofl`=1.
- Backpressure: hold `rsp_ready`=0 for 4 cycles after `rsp_valid` while presenting a new request. Required: `rsp_data` is stable, `req_ready`=0, and the new request is not accepted until the cycle after the handshake.
- Back-to-back ADD, ADD32, SEQ with `rsp_ready`=1 → responses in order, with issue intervals 3, 4, 3.
